// File: rtl/store_unit_if.sv
// store_unit_if: bundles the memory-stage request handshake and the
// data-memory write port seen by store_unit.
//   master : the environment side (memory stage issuing stores, data memory responding)
//   slave  : the store unit itself
interface store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  store_funct3;
    logic [31:0] addr;
    logic [31:0] wdata_in;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic        dmem_resp;
    logic        store_done;
    logic        misaligned;

    modport master (
        output req_valid, store_funct3, addr, wdata_in, dmem_resp,
        input  req_ready, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
               store_done, misaligned
    );

    modport slave (
        input  req_valid, store_funct3, addr, wdata_in, dmem_resp,
        output req_ready, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
               store_done, misaligned
    );
endinterface

// File: rtl/store_unit.sv
// store_unit: memory-stage store engine. Accepts sb/sh/sw, lane-aligns the
// data, builds the byte-enable mask and holds a registered write on the
// data-memory port until dmem_resp.
// Optional feature macro: STORE_SPLIT_EN
//   defined   : word-crossing stores become two word accesses (FIRST then SECOND)
//   undefined : word-crossing stores are dropped with a one-cycle misaligned pulse
module store_unit (
    input  logic         clk,
    input  logic         rst_n,
    store_unit_if.slave  bus
);

`ifdef STORE_SPLIT_EN
    typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;
`else
    typedef enum logic [1:0] {IDLE, FIRST} state_t;
`endif

    state_t      state;
    state_t      state_next;

    logic        write_q,   write_next;
    logic [31:0] address_q, address_next;
    logic [31:0] wdata_q,   wdata_next;
    logic [3:0]  mbe_q,     mbe_next;
    logic        done_q,    done_next;
    logic        mis_q,     mis_next;

`ifdef STORE_SPLIT_EN
    logic [31:0] hi_address_q, hi_address_next;
    logic [31:0] hi_wdata_q,   hi_wdata_next;
    logic [3:0]  hi_mbe_q,     hi_mbe_next;
    logic        split_q,      split_next;
`endif

    logic [1:0]  offset;
    logic [3:0]  size_mask;
    logic [31:0] size_data;
    logic [7:0]  lane_mask;
    logic [63:0] lane_data;
    logic        crosses;
    logic [31:0] word_address;
    logic        unused_bits;

    // Lane alignment of the incoming request over an 8-byte window (two words)
    always_comb begin
        offset = bus.addr[1:0];
        case (bus.store_funct3[1:0])
            2'b00: begin
                size_mask = 4'b0001;
                size_data = {24'h000000, bus.wdata_in[7:0]};
            end
            2'b01: begin
                size_mask = 4'b0011;
                size_data = {16'h0000, bus.wdata_in[15:0]};
            end
            default: begin
                size_mask = 4'b1111;
                size_data = bus.wdata_in;
            end
        endcase
        lane_mask    = {4'b0000, size_mask} << offset;
        lane_data    = {32'h00000000, size_data} << {offset, 3'b000};
        crosses      = |lane_mask[7:4];
        word_address = {bus.addr[31:2], 2'b00};
    end

`ifdef STORE_SPLIT_EN
    assign unused_bits = bus.store_funct3[2];
`else
    assign unused_bits = ^{bus.store_funct3[2], lane_data[63:32]};
`endif

    // State register and registered dmem/pulse outputs; reset drops any in-flight store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            write_q   <= 1'b0;
            address_q <= 32'h0;
            wdata_q   <= 32'h0;
            mbe_q     <= 4'h0;
            done_q    <= 1'b0;
            mis_q     <= 1'b0;
`ifdef STORE_SPLIT_EN
            hi_address_q <= 32'h0;
            hi_wdata_q   <= 32'h0;
            hi_mbe_q     <= 4'h0;
            split_q      <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            write_q   <= write_next;
            address_q <= address_next;
            wdata_q   <= wdata_next;
            mbe_q     <= mbe_next;
            done_q    <= done_next;
            mis_q     <= mis_next;
`ifdef STORE_SPLIT_EN
            hi_address_q <= hi_address_next;
            hi_wdata_q   <= hi_wdata_next;
            hi_mbe_q     <= hi_mbe_next;
            split_q      <= split_next;
`endif
        end
    end

    // Next-state and next-output logic; dmem fields hold unless an access starts or advances
    always_comb begin
        state_next   = state;
        write_next   = write_q;
        address_next = address_q;
        wdata_next   = wdata_q;
        mbe_next     = mbe_q;
        done_next    = 1'b0;
        mis_next     = 1'b0;
`ifdef STORE_SPLIT_EN
        hi_address_next = hi_address_q;
        hi_wdata_next   = hi_wdata_q;
        hi_mbe_next     = hi_mbe_q;
        split_next      = split_q;
`endif
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
`ifdef STORE_SPLIT_EN
                    state_next      = FIRST;
                    write_next      = 1'b1;
                    address_next    = word_address;
                    wdata_next      = lane_data[31:0];
                    mbe_next        = lane_mask[3:0];
                    hi_address_next = word_address + 32'd4;
                    hi_wdata_next   = lane_data[63:32];
                    hi_mbe_next     = lane_mask[7:4];
                    split_next      = crosses;
`else
                    if (crosses) begin
                        mis_next = 1'b1;
                    end else begin
                        state_next   = FIRST;
                        write_next   = 1'b1;
                        address_next = word_address;
                        wdata_next   = lane_data[31:0];
                        mbe_next     = lane_mask[3:0];
                    end
`endif
                end
            end
            FIRST: begin
                if (bus.dmem_resp) begin
`ifdef STORE_SPLIT_EN
                    if (split_q) begin
                        state_next   = SECOND;
                        address_next = hi_address_q;
                        wdata_next   = hi_wdata_q;
                        mbe_next     = hi_mbe_q;
                    end else begin
                        state_next = IDLE;
                        write_next = 1'b0;
                        done_next  = 1'b1;
                    end
`else
                    state_next = IDLE;
                    write_next = 1'b0;
                    done_next  = 1'b1;
`endif
                end
            end
`ifdef STORE_SPLIT_EN
            SECOND: begin
                if (bus.dmem_resp) begin
                    state_next = IDLE;
                    write_next = 1'b0;
                    done_next  = 1'b1;
                end
            end
`endif
            default: begin
                state_next = IDLE;
                write_next = 1'b0;
            end
        endcase
    end

    assign bus.req_ready    = (state == IDLE);
    assign bus.dmem_write   = write_q;
    assign bus.dmem_address = address_q;
    assign bus.dmem_wdata   = wdata_q;
    assign bus.dmem_mbe     = mbe_q;
    assign bus.store_done   = done_q;
    assign bus.misaligned   = mis_q;

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed self-checking bench for store_unit.
// Expected values are hand-computed; crossing-store expectations follow
// whether STORE_SPLIT_EN is defined for the build.
module tb_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    store_unit_if bus();

    store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, rising edge active
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive all request-side and response inputs
    task automatic applyStimulus(input logic valid, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic resp);
        bus.req_valid    = valid;
        bus.store_funct3 = f3;
        bus.addr         = a;
        bus.wdata_in     = d;
        bus.dmem_resp    = resp;
    endtask

    // Compare every DUT output at once
    task automatic checkOutput(input string tag, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] m,
                               input logic rdy, input logic done, input logic mis);
        logic [71:0] obs;
        logic [71:0] exp;
        obs = {bus.dmem_write, bus.dmem_address, bus.dmem_wdata, bus.dmem_mbe,
               bus.req_ready, bus.store_done, bus.misaligned};
        exp = {w, a, d, m, rdy, done, mis};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare only the control outputs {dmem_write, req_ready, store_done, misaligned}
    task automatic checkControl(input string tag, input logic w, input logic rdy,
                                input logic done, input logic mis);
        logic [3:0] obs;
        logic [3:0] exp;
        obs = {bus.dmem_write, bus.req_ready, bus.store_done, bus.misaligned};
        exp = {w, rdy, done, mis};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One word-crossing store: two accesses when splitting, otherwise a misaligned pulse
    task automatic runCrossing(input string tag, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] m0,
                               input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] m1);
        applyStimulus(1'b1, f3, a, d, 1'b0);
        tick();
`ifdef STORE_SPLIT_EN
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        checkOutput({tag, "_w0"}, 1'b1, a0, d0, m0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput({tag, "_w1"}, 1'b1, a1, d1, m1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        checkControl({tag, "_done"}, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        checkControl({tag, "_after"}, 1'b0, 1'b1, 1'b0, 1'b0);
`else
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        checkControl({tag, "_mis"}, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checkControl({tag, "_after"}, 1'b0, 1'b1, 1'b0, 1'b0);
        $display("[TB] %s dropped; split fields %h/%h/%b %h/%h/%b unused", tag, a0, d0, m0, a1, d1, m1);
`endif
    endtask

    // Guard against a hung run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence
    initial begin
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        checkOutput("reset_state", 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Response while idle must be ignored
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        checkControl("idle_resp", 1'b0, 1'b1, 1'b0, 1'b0);

        // sb with response one cycle after the write; inputs scrambled after accept
        applyStimulus(1'b1, 3'b000, 32'h0000_2002, 32'h1234_5678, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b010, 32'hDEAD_BEE0, 32'hFFFF_FFFF, 1'b0);
        checkOutput("sb_write", 1'b1, 32'h0000_2000, 32'h0078_0000, 4'b0100, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("sb_hold", 1'b1, 32'h0000_2000, 32'h0078_0000, 4'b0100, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'hDEAD_BEE0, 32'hFFFF_FFFF, 1'b1);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        checkControl("sb_done", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        checkControl("sb_done_pulse", 1'b0, 1'b1, 1'b0, 1'b0);

        // sh with same-cycle response, then immediate re-accept of an aligned sw
        applyStimulus(1'b1, 3'b001, 32'h0000_3001, 32'hFFFF_BEEF, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        checkOutput("sh_write", 1'b1, 32'h0000_3000, 32'h00BE_EF00, 4'b0110, 1'b0, 1'b0, 1'b0);
        tick();
        checkControl("sh_done", 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        checkOutput("sw_b2b", 1'b1, 32'h0000_4000, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("sw_stall", 1'b1, 32'h0000_4000, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        checkControl("sw_done", 1'b0, 1'b1, 1'b1, 1'b0);

        // sh in the upper half, then funct3 3'b111 treated as sw
        applyStimulus(1'b1, 3'b001, 32'h0000_5002, 32'h1234_ABCD, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        checkOutput("sh_upper", 1'b1, 32'h0000_5000, 32'hABCD_0000, 4'b1100, 1'b0, 1'b0, 1'b0);
        tick();
        checkControl("sh_upper_done", 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'b111, 32'h0000_6000, 32'h8765_4321, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        checkOutput("f3_111_sw", 1'b1, 32'h0000_6000, 32'h8765_4321, 4'b1111, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        checkControl("f3_111_done", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();

        // Word-crossing stores, including address wrap at the top of memory
        runCrossing("sw_cross", 3'b010, 32'h0000_1003, 32'hAABB_CCDD,
                    32'h0000_1000, 32'hDD00_0000, 4'b1000,
                    32'h0000_1004, 32'h00AA_BBCC, 4'b0111);
        runCrossing("sw_wrap", 3'b010, 32'hFFFF_FFFE, 32'h1122_3344,
                    32'hFFFF_FFFC, 32'h3344_0000, 4'b1100,
                    32'h0000_0000, 32'h0000_1122, 4'b0011);
        runCrossing("sh_cross", 3'b001, 32'h0000_5003, 32'h0000_ABCD,
                    32'h0000_5000, 32'hCD00_0000, 4'b1000,
                    32'h0000_5004, 32'h0000_00AB, 4'b0001);

        // Reset while a store is in its first access
`ifdef STORE_SPLIT_EN
        applyStimulus(1'b1, 3'b010, 32'h0000_1003, 32'hAABB_CCDD, 1'b0);
`else
        applyStimulus(1'b1, 3'b010, 32'h0000_7000, 32'hAABB_CCDD, 1'b0);
`endif
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        checkControl("rst_pre", 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async", 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        checkControl("rst_no_done", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkControl("rst_no_done2", 1'b0, 1'b1, 1'b0, 1'b0);

        // Normal store after reset
        applyStimulus(1'b1, 3'b000, 32'h0000_8001, 32'h0000_00A5, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        checkOutput("post_rst_sb", 1'b1, 32'h0000_8000, 32'h0000_A500, 4'b0010, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        checkControl("post_rst_done", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_unit.md
# store_unit

Memory-stage store engine: the write-side counterpart of the writeback load-extraction logic. Accepts one store (sb/sh/sw) per handshake from the memory stage, lane-aligns the store data, generates the byte-enable mask, and drives the data-memory write port. It holds each request until the memory responds and splits stores that cross a word boundary into two word accesses. The pipeline stalls while `req_ready` is low.

## Interface
- No parameters; data and address width fixed at 32.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: the memory stage presents a store.
- `req_ready` out 1: `state==IDLE`; the store is accepted when `req_valid && req_ready`.
- `store_funct3` in 3: 000=sb, 001=sh, 010=sw. Bit 2 is ignored; 2'b11 is treated as sw.
- `addr` in 32: byte address (ALU output).
- `wdata_in` in 32: rs2 value; only the low 8/16/32 bits are used.
- `dmem_write` out 1: write request, held until `dmem_resp`.
- `dmem_address` out 32: word-aligned address.
- `dmem_wdata` out 32: lane-aligned data; bytes outside the mask are 0.
- `dmem_mbe` out 4: byte enables.
- `dmem_resp` in 1: write completion, 1-cycle pulse.
- `store_done` out 1: 1-cycle pulse after a store fully completes.
- `misaligned` out 1: 1-cycle pulse for a dropped word-crossing store (only when `STORE_SPLIT_EN` is undefined).

## Operation
- Size n = 1, 2 or 4 bytes; offset o = `addr[1:0]`.
- 8-bit lane mask m8 = ((1<<n)-1) << o.
- 64-bit data d64 = zero-extended low n bytes << 8·o.
- Split is needed iff m8[7:4] != 0.
- Word 0: address {addr[31:2],2'b00}, mbe m8[3:0], wdata d64[31:0].
- Word 1: word 0 address + 4, modulo 2^32 (wraps 0xFFFFFFFC→0x00000000); mbe m8[7:4], wdata d64[63:32].
- FSM states: IDLE, FIRST, SECOND.
  - IDLE: on accept, register the request, compute the word 0/1 fields, go to FIRST.
  - FIRST: drive word 0 with `dmem_write`=1. On `dmem_resp`, go to SECOND if a split is needed, else go to IDLE and pulse `store_done`.
  - SECOND: drive word 1. On `dmem_resp`, go to IDLE and pulse `store_done`.
- `dmem_resp` in IDLE is ignored.
- All `dmem_*` outputs are registered and stable while `dmem_write`=1.
- Input changes after the accept have no effect on the current store.
- Reset values: `dmem_write`=0, `dmem_address`=0, `dmem_wdata`=0, `dmem_mbe`=0, `store_done`=0, `misaligned`=0. `req_ready`=1 (state IDLE).
- Reset mid-operation: `rst_n` low forces IDLE and `dmem_write`=0 immediately. The in-flight store is dropped and no `store_done` is issued.

## Timing
- Accept at edge T; `dmem_write` is high in cycle T+1.
- A response in the same cycle as the request completes that access.
- Minimum latency from accept to `store_done`:
  - 2 cycles unsplit: accept T, write T+1, `store_done` and `req_ready` at T+2.
  - 3 cycles split.
- Back-to-back: a new accept is allowed in the `store_done` cycle.
- There is no request overlap; at most one store is in flight.

## Configuration
- `STORE_SPLIT_EN` defined: word-crossing stores are performed as the two-access FIRST→SECOND sequence. `misaligned` is tied to 0.
- `STORE_SPLIT_EN` undefined:
  - SECOND is removed.
  - A word-crossing store causes no memory access. It pulses `misaligned` at T+1, returns to IDLE at T+1, and issues no `store_done`.
  - Non-crossing stores behave identically to the defined case.

## Test plan
- sb, addr 0x2002, wdata_in 0x12345678, resp 1 cycle after write → one access: address 0x2000, mbe 0100, wdata 0x00780000; `store_done` 1 cycle after resp.
- sh, addr 0x3001, wdata_in 0xFFFFBEEF → single access: address 0x3000, mbe 0110, wdata 0x00BEEF00.
- sw, addr 0x1003, wdata_in 0xAABBCCDD, split enabled → access 1: 0x1000/1000/0xDD000000; access 2: 0x1004/0111/0x00AABBCC; one `store_done`. With split disabled → no `dmem_write`, one `misaligned` pulse.
- sw, addr 0xFFFFFFFE, split enabled → accesses 0xFFFFFFFC/1100 then 0x00000000/0011.
- Hold `dmem_resp` low 5 cycles → outputs stable, `req_ready`=0 throughout. Same-cycle resp → 2-cycle store; immediate re-accept.
- `rst_n` low during FIRST of a split store → `dmem_write` falls asynchronously; no `store_done`; the next store behaves normally.
